// File: rtl/gpio_pad_ctrl_if.sv
// Register-block side of the GPIO pad front end: drive controls in, filtered pad
// values, change pulses and external-clock events out.
interface gpio_pad_ctrl_if #(
    parameter int unsigned GPIO_W = 32,
    parameter int unsigned DEB_W  = 16
);
    logic [GPIO_W-1:0] out_pad_o;
    logic [GPIO_W-1:0] oen_padoen_o;
    logic [GPIO_W-1:0] od_en;
    logic [GPIO_W-1:0] deb_en;
    logic [DEB_W-1:0]  deb_max;
    logic [GPIO_W-1:0] in_pad_i;
    logic [GPIO_W-1:0] in_chg_o;
    logic              gpio_eclk;
    logic              eclk_rise;
    logic              eclk_fall;

    modport master (
        output out_pad_o, oen_padoen_o, od_en, deb_en, deb_max,
        input  in_pad_i, in_chg_o, gpio_eclk, eclk_rise, eclk_fall
    );

    modport slave (
        input  out_pad_o, oen_padoen_o, od_en, deb_en, deb_max,
        output in_pad_i, in_chg_o, gpio_eclk, eclk_rise, eclk_fall
    );
endinterface

// File: rtl/gpio_pad_ctrl.sv
// GPIO pad front end: push-pull/open-drain pad drive, synchronised and debounced
// pad inputs with change pulses, and a synchronised external clock with edge pulses.
module gpio_pad_ctrl #(
    parameter int unsigned GPIO_W      = 32,
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned DEB_W       = 16
) (
    input  logic              pclk,
    input  logic              presetn,
    gpio_pad_ctrl_if.slave    bus,
    inout  wire  [GPIO_W-1:0] io_pad,
    input  logic              ext_clk_pad_i
);

    logic [GPIO_W-1:0] pad_oe;
    logic [GPIO_W-1:0] sync_q [SYNC_STAGES];
    logic [GPIO_W-1:0] sync;
    logic [GPIO_W-1:0] stable_q, stable_d;
    logic [GPIO_W-1:0] chg_q, chg_d;
    logic [DEB_W-1:0]  cnt_q [GPIO_W];
    logic [DEB_W-1:0]  cnt_d [GPIO_W];
    logic [DEB_W-1:0]  deb_thr_m1;
    logic [SYNC_STAGES-1:0] eclk_sync_q;
    logic              eclk_prev_q;
    logic              eclk_level;

    // Open-drain pins only ever drive low; a high output releases the pad.
    assign pad_oe = bus.oen_padoen_o & ~(bus.od_en & bus.out_pad_o);

    for (genvar g = 0; g < GPIO_W; g++) begin : g_pad
        assign io_pad[g] = pad_oe[g] ? bus.out_pad_o[g] : 1'bz;
    end

    always_ff @(posedge pclk or negedge presetn) begin
        if (!presetn) begin
            for (int s = 0; s < int'(SYNC_STAGES); s++) begin
                sync_q[s] <= '0;
            end
        end else begin
            sync_q[0] <= io_pad;
            for (int s = 1; s < int'(SYNC_STAGES); s++) begin
                sync_q[s] <= sync_q[s-1];
            end
        end
    end

    assign sync = sync_q[SYNC_STAGES-1];

    // Threshold minus one; a zero threshold behaves like bypass.
    assign deb_thr_m1 = (bus.deb_max != {DEB_W{1'b0}}) ? bus.deb_max - DEB_W'(1)
                                                       : {DEB_W{1'b0}};

    always_comb begin
        stable_d = stable_q;
        chg_d    = '0;
        for (int i = 0; i < int'(GPIO_W); i++) begin
            cnt_d[i] = cnt_q[i];
            if (sync[i] == stable_q[i]) begin
                cnt_d[i] = '0;
            end else if (cnt_q[i] >= (bus.deb_en[i] ? deb_thr_m1 : {DEB_W{1'b0}})) begin
                stable_d[i] = sync[i];
                cnt_d[i]    = '0;
                chg_d[i]    = 1'b1;
            end else if (cnt_q[i] != {DEB_W{1'b1}}) begin
                cnt_d[i] = cnt_q[i] + DEB_W'(1);
            end
        end
    end

    always_ff @(posedge pclk or negedge presetn) begin
        if (!presetn) begin
            stable_q <= '0;
            chg_q    <= '0;
            for (int i = 0; i < int'(GPIO_W); i++) begin
                cnt_q[i] <= '0;
            end
        end else begin
            stable_q <= stable_d;
            chg_q    <= chg_d;
            for (int i = 0; i < int'(GPIO_W); i++) begin
                cnt_q[i] <= cnt_d[i];
            end
        end
    end

    assign bus.in_pad_i = stable_q;
    assign bus.in_chg_o = chg_q;

    always_ff @(posedge pclk or negedge presetn) begin
        if (!presetn) begin
            eclk_sync_q <= '0;
            eclk_prev_q <= 1'b0;
        end else begin
            eclk_sync_q <= {eclk_sync_q[SYNC_STAGES-2:0], ext_clk_pad_i};
            eclk_prev_q <= eclk_level;
        end
    end

    assign eclk_level    = eclk_sync_q[SYNC_STAGES-1];
    assign bus.gpio_eclk = eclk_level;
    assign bus.eclk_rise = eclk_level & ~eclk_prev_q;
    assign bus.eclk_fall = ~eclk_level & eclk_prev_q;

endmodule

// File: tb/tb_gpio_pad_ctrl.sv
// Directed bench for gpio_pad_ctrl: drive modes, bypass latency table, debounce,
// external clock edges and reset in the middle of a debounce count.
module tb_gpio_pad_ctrl;

    localparam int unsigned W    = 32;
    localparam int unsigned SYNC = 2;
    localparam int unsigned DW   = 16;

    logic          pclk = 1'b0;
    logic          presetn;
    logic          ext_clk;
    logic [W-1:0]  tb_en;
    logic [W-1:0]  tb_val;
    tri   [W-1:0]  io_pad;

    int checks = 0;
    int errors = 0;

    gpio_pad_ctrl_if #(.GPIO_W(W), .DEB_W(DW)) bus ();

    gpio_pad_ctrl #(.GPIO_W(W), .SYNC_STAGES(SYNC), .DEB_W(DW)) dut (
        .pclk          (pclk),
        .presetn       (presetn),
        .bus           (bus),
        .io_pad        (io_pad),
        .ext_clk_pad_i (ext_clk)
    );

    // Bench-side pad drivers stand in for external devices and pulls.
    for (genvar g = 0; g < W; g++) begin : g_tb_pad
        assign io_pad[g] = tb_en[g] ? tb_val[g] : 1'bz;
    end

    always #5 pclk = ~pclk;

    typedef struct {
        logic [31:0] pad;
        logic [31:0] exp_in;
        logic [31:0] exp_chg;
    } vec_t;

    vec_t vecs[12];

    task automatic tick();
        @(posedge pclk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %h want %h", name, act, exp);
        end
    endtask

    int   rises;
    int   falls;
    int   lag_err;
    logic prev_ext;
    logic seen;

    initial begin
        // Bypass, SYNC_STAGES=2: a pad value shows on in_pad_i three rows later.
        vecs[0]  = '{pad: 32'h0000_0001, exp_in: 32'h0000_0000, exp_chg: 32'h0000_0000};
        vecs[1]  = '{pad: 32'h0000_0001, exp_in: 32'h0000_0000, exp_chg: 32'h0000_0000};
        vecs[2]  = '{pad: 32'h0000_0003, exp_in: 32'h0000_0001, exp_chg: 32'h0000_0001};
        vecs[3]  = '{pad: 32'h0000_0002, exp_in: 32'h0000_0001, exp_chg: 32'h0000_0000};
        vecs[4]  = '{pad: 32'h0000_0002, exp_in: 32'h0000_0003, exp_chg: 32'h0000_0002};
        vecs[5]  = '{pad: 32'h0000_0002, exp_in: 32'h0000_0002, exp_chg: 32'h0000_0001};
        vecs[6]  = '{pad: 32'hF000_0000, exp_in: 32'h0000_0002, exp_chg: 32'h0000_0000};
        vecs[7]  = '{pad: 32'hF000_0000, exp_in: 32'h0000_0002, exp_chg: 32'h0000_0000};
        vecs[8]  = '{pad: 32'h0000_0000, exp_in: 32'hF000_0000, exp_chg: 32'hF000_0002};
        vecs[9]  = '{pad: 32'h0000_0000, exp_in: 32'hF000_0000, exp_chg: 32'h0000_0000};
        vecs[10] = '{pad: 32'h0000_0000, exp_in: 32'h0000_0000, exp_chg: 32'hF000_0000};
        vecs[11] = '{pad: 32'h0000_0000, exp_in: 32'h0000_0000, exp_chg: 32'h0000_0000};

        presetn          = 1'b0;
        ext_clk          = 1'b0;
        tb_en            = '1;
        tb_val           = '1;
        bus.out_pad_o    = '0;
        bus.oen_padoen_o = '0;
        bus.od_en        = '0;
        bus.deb_en       = '0;
        bus.deb_max      = '0;

        // Reset holds outputs low even with all pads high.
        repeat (3) tick();
        check("rst_in_pad", bus.in_pad_i, 32'h0);
        check("rst_in_chg", bus.in_chg_o, 32'h0);
        check("rst_eclk", {29'h0, bus.gpio_eclk, bus.eclk_rise, bus.eclk_fall}, 32'h0);
        tb_val = '0;
        tick();
        presetn = 1'b1;
        repeat (4) tick();

        // Push-pull upper half; lower half undriven by the DUT so the bench owns it.
        bus.oen_padoen_o = 32'hFFFF_0000;
        bus.out_pad_o    = 32'hA5A5_5A5A;
        tb_en            = 32'h0000_FFFF;
        tb_val           = 32'h0000_A5A5;
        #1;
        check("drv_hi", {16'h0, io_pad[31:16]}, 32'h0000_A5A5);
        check("drv_lo_released", {16'h0, io_pad[15:0]}, 32'h0000_A5A5);
        repeat (3) tick();
        check("readback", bus.in_pad_i, 32'hA5A5_A5A5);
        bus.oen_padoen_o = '0;
        bus.out_pad_o    = '0;
        tb_en            = '1;
        tb_val           = '0;
        repeat (5) tick();

        // Open-drain pin 3: low drives 0, high releases to the bench pull-up.
        bus.oen_padoen_o = 32'h8;
        bus.od_en        = 32'h8;
        bus.out_pad_o    = 32'h0;
        tb_en            = ~32'h8;
        #1;
        check("od_low", {31'h0, io_pad[3]}, 32'h0);
        tick();
        bus.out_pad_o = 32'h8;
        tb_en         = '1;
        tb_val        = 32'h8;
        #1;
        check("od_pullup", {31'h0, io_pad[3]}, 32'h1);
        repeat (2) tick();
        check("od_lat2", bus.in_pad_i, 32'h0);
        tick();
        check("od_lat3", bus.in_pad_i, 32'h8);
        bus.oen_padoen_o = '0;
        bus.od_en        = '0;
        bus.out_pad_o    = '0;
        tb_val           = '0;
        repeat (5) tick();

        for (int k = 0; k < 12; k++) begin
            tb_val = vecs[k].pad;
            tick();
            check($sformatf("vec%0d_in", k), bus.in_pad_i, vecs[k].exp_in);
            check($sformatf("vec%0d_chg", k), bus.in_chg_o, vecs[k].exp_chg);
        end

        // Pin 5 debounced at 8: a 7-cycle pulse must vanish.
        bus.deb_en  = 32'h20;
        bus.deb_max = 16'd8;
        seen        = 1'b0;
        tb_val      = 32'h20;
        for (int k = 0; k < 16; k++) begin
            if (k == 7) tb_val = '0;
            tick();
            if (bus.in_pad_i[5] || bus.in_chg_o[5]) seen = 1'b1;
        end
        check("deb_glitch", {31'h0, seen}, 32'h0);

        tb_val = 32'h20;
        repeat (9) tick();
        check("deb_e9", bus.in_pad_i, 32'h0);
        tick();
        check("deb_e10_in", bus.in_pad_i, 32'h20);
        check("deb_e10_chg", bus.in_chg_o, 32'h20);
        tick();
        check("deb_e11_chg", bus.in_chg_o, 32'h0);
        repeat (9) tick();
        tb_val = '0;
        repeat (6) tick();
        check("deb_hold", bus.in_pad_i, 32'h20);
        bus.deb_max = 16'd0;
        tick();
        check("deb_max0_in", bus.in_pad_i, 32'h0);
        check("deb_max0_chg", bus.in_chg_o, 32'h20);

        // Clearing deb_en mid-count releases on the next mismatch cycle.
        bus.deb_max = 16'd8;
        repeat (3) tick();
        tb_val = 32'h20;
        repeat (5) tick();
        check("deben_clr_pre", bus.in_pad_i, 32'h0);
        bus.deb_en = '0;
        tick();
        check("deben_clr_post", bus.in_pad_i, 32'h20);
        tb_val = '0;
        repeat (4) tick();

        // 10 MHz external clock against 100 MHz pclk, edges offset from pclk.
        rises    = 0;
        falls    = 0;
        lag_err  = 0;
        prev_ext = 1'b0;
        fork
            begin
                #3;
                repeat (5) begin
                    ext_clk = 1'b1;
                    #50;
                    ext_clk = 1'b0;
                    #50;
                end
            end
            begin
                for (int k = 0; k < 60; k++) begin
                    tick();
                    if (bus.eclk_rise) rises++;
                    if (bus.eclk_fall) falls++;
                    if (bus.gpio_eclk !== prev_ext) lag_err++;
                    prev_ext = ext_clk;
                end
            end
        join
        check("eclk_rises", rises, 32'd5);
        check("eclk_falls", falls, 32'd5);
        check("eclk_lag", lag_err, 32'd0);

        // Reset during a debounce count on pin 1; pin 0 stays in bypass.
        bus.deb_en  = 32'h2;
        bus.deb_max = 16'd16;
        tb_val      = 32'h3;
        repeat (12) tick();
        check("pre_rst", bus.in_pad_i, 32'h1);
        presetn = 1'b0;
        #2;
        check("rst_async", bus.in_pad_i, 32'h0);
        repeat (2) tick();
        presetn = 1'b1;
        repeat (17) tick();
        check("post_rst_e17", bus.in_pad_i, 32'h1);
        tick();
        check("post_rst_e18_in", bus.in_pad_i, 32'h3);
        check("post_rst_e18_chg", bus.in_chg_o, 32'h2);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/gpio_pad_ctrl.md
Name: gpio_pad_ctrl

Overview:
Parametrised pad-side front end for the APB GPIO, replacing the fixed 32-bit combinational pad interface. It drives each pad in push-pull or open-drain mode. It samples pad inputs through a multi-stage synchroniser and an optional per-pin debounce filter, and flags filtered input changes. It also synchronises the external GPIO clock and produces edge pulses for the register block.

Parameters:
GPIO_W, 32, number of pads/channels (1..32).
SYNC_STAGES, 2, synchroniser depth for pad inputs and external clock (legal 2..4).
DEB_W, 16, width of the debounce threshold and per-pin counters.

Ports:
pclk  input  1  APB/system clock; sole clock of the block.
presetn  input  1  asynchronous active-low reset.
out_pad_o  input  GPIO_W  output data per pin from the register block.
oen_padoen_o  input  GPIO_W  output enable per pin (1 = output).
od_en  input  GPIO_W  open-drain mode per pin (1 = open-drain).
deb_en  input  GPIO_W  debounce enable per pin.
deb_max  input  DEB_W  debounce threshold in pclk cycles; shared by all pins.
io_pad  inout  GPIO_W  bidirectional pads.
in_pad_i  output  GPIO_W  synchronised, filtered pad value to the register block.
in_chg_o  output  GPIO_W  1-cycle pulse per pin when in_pad_i changes.
ext_clk_pad_i  input  1  asynchronous external clock pad.
gpio_eclk  output  1  synchronised external clock level.
eclk_rise  output  1  1-cycle pulse on a synchronised rising edge of ext_clk_pad_i.
eclk_fall  output  1  1-cycle pulse on a synchronised falling edge.

Behaviour:
- Clocking and reset: single clock pclk. Reset is asynchronous and active-low on presetn.
- Reset values: all synchroniser flops, stable values, counters, in_pad_i, in_chg_o, gpio_eclk, eclk_rise and eclk_fall are 0.
- Pad drive (combinational, per pin):
  - oen=0: pad is Z.
  - oen=1, od_en=0: pad = out_pad_o.
  - oen=1, od_en=1: pad = 0 when out_pad_o=0, Z when out_pad_o=1.
  - Pad drive is unaffected by presetn.
- Input path: io_pad is sampled every cycle regardless of oen, so output pins read back the pad level. An undriven pad samples X/Z as-is; the bench supplies pulls.
- Synchroniser: SYNC_STAGES flops per pin, producing sync[i].
- Filter, per pin: one stable[i] register (drives in_pad_i[i]) and one cnt[i] counter. Effective threshold T = deb_max when deb_en[i]=1 and deb_max!=0; otherwise T = 1 (bypass).
  - sync==stable: cnt <= 0.
  - sync!=stable and cnt >= T-1: stable <= sync, cnt <= 0, in_chg_o[i] asserted for exactly the following cycle.
  - Otherwise: cnt <= cnt+1. cnt saturates at all-ones and never wraps.
- Filter latency:
  - A pad change must persist T consecutive sync cycles to propagate.
  - Pad edge to in_pad_i change = SYNC_STAGES + T cycles (bypass: SYNC_STAGES+1).
  - A glitch shorter than T cycles at sync produces no change and no in_chg_o pulse.
- Mid-operation changes:
  - deb_max lowered below the current cnt: the update occurs on the next mismatch cycle (>= compare).
  - deb_en cleared mid-count: T becomes 1 and the update occurs on the next mismatch cycle.
- Reset mid-count: all counters clear and in_pad_i returns to 0. After release, a pad held at 1 re-propagates with the full latency.
- External clock:
  - ext_clk_pad_i passes through SYNC_STAGES flops, giving gpio_eclk.
  - One extra flop holds the previous level.
  - eclk_rise = level & ~prev; eclk_fall = ~level & prev; each is one cycle wide.
  - ext_clk_pad_i must be slower than pclk/2; faster toggling may drop edges, with no error flag.
- Pins are fully independent. Simultaneous changes on several pins update in the same cycle, each with its own pulse.
- GPIO_W < 32 has no unused logic; all buses are exactly GPIO_W wide.

Test Plan:
- Reset/drive: presetn=0 → in_pad_i=0, in_chg_o=0, gpio_eclk=0. Then oen=32'hFFFF_0000, out=32'hA5A5_5A5A, od_en=0 → io_pad[31:16]=16'hA5A5 and io_pad[15:0]=Z.
- Open-drain: oen[3]=1, od_en[3]=1 → out[3]=0 drives pad 0; out[3]=1 releases to Z; with a bench pull-up, pad reads 1 and in_pad_i[3]=1 after 3 cycles (SYNC_STAGES=2, bypass).
- Bypass latency: deb_en=0, pad[0] toggled 0→1 → in_pad_i[0]=1 exactly 3 cycles later with a 1-cycle in_chg_o[0] pulse; pad[0] returned 1→0 → second pulse.
- Debounce: deb_en[5]=1, deb_max=8. A 7-cycle high pulse on pad[5] → no change and no pulse. A 20-cycle high → in_pad_i[5]=1 at edge+10 cycles, one pulse. Then deb_max changed to 0 mid-count → next mismatch updates immediately.
- External clock: pclk 100 MHz, ext_clk 10 MHz, 5 periods → gpio_eclk follows with a 2-cycle lag; exactly 5 eclk_rise and 5 eclk_fall single-cycle pulses.
- Reset mid-operation: deb_max=16, pad[1] high, presetn pulsed low at count 10 → in_pad_i[1]=0 immediately; after release it rises at +18 cycles.
